// File: rtl/des_key_schedule.sv
// DES key schedule: emits the 16 round subkeys (forward or reversed) over a valid/ready handshake.
// Optional odd-parity key check is compiled in with `define DES_KEY_SCHEDULE_PARITY_CHK_EN.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] key,
  input  logic        decrypt,
  output logic        busy,
  output logic [1:48] subkey,
  output logic [3:0]  round_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
    return r;
  endfunction

  // Shift table entry s[i+1] is 2 except for key indices 1, 2, 9 and 16.
  function automatic logic shift_two(input logic [3:0] i);
    return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  state_t      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [1:56] cd_load;
  logic        key_ok;
  logic        accept;
  logic        adv;
  logic        last;

  assign cd_load = pc1(key);
  assign accept  = (state_q == IDLE) && start && key_ok;
  assign adv     = (state_q == RUN) && subkey_ready;
  assign last    = dec_q ? (idx_q == 4'd0) : (idx_q == 4'd15);

`ifdef DES_KEY_SCHEDULE_PARITY_CHK_EN
  logic parity_err_q, parity_err_d;

  function automatic logic parity_ok(input logic [1:64] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^k[b*8+1 +: 8]);
    return ok;
  endfunction

  assign key_ok = parity_ok(key);

  always_comb begin
    parity_err_d = parity_err_q;
    if (state_q == IDLE && start) parity_err_d = !key_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (adv && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == RUN);
    subkey_valid = (state_q == RUN);
  end

  // Encrypt loads C1/D1 (one left shift applied); decrypt loads C16/D16, which equal C0/D0.
  // The final acceptance does not rotate, so an encrypt run ends back at C0/D0.
  always_comb begin
    c_d    = c_q;
    d_d    = d_q;
    idx_d  = idx_q;
    dec_d  = dec_q;
    done_d = 1'b0;
    if (accept) begin
      dec_d = decrypt;
      if (decrypt) begin
        c_d   = cd_load[1:28];
        d_d   = cd_load[29:56];
        idx_d = 4'd15;
      end else begin
        c_d   = rotl(cd_load[1:28], 1'b0);
        d_d   = rotl(cd_load[29:56], 1'b0);
        idx_d = 4'd0;
      end
    end else if (adv) begin
      if (last) begin
        done_d = 1'b1;
      end else if (dec_q) begin
        c_d   = rotr(c_q, shift_two(idx_q));
        d_d   = rotr(d_q, shift_two(idx_q));
        idx_d = idx_q - 4'd1;
      end else begin
        c_d   = rotl(c_q, shift_two(idx_q + 4'd1));
        d_d   = rotl(d_q, shift_two(idx_q + 4'd1));
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      d_q    <= '0;
      idx_q  <= '0;
      dec_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      idx_q  <= idx_d;
      dec_q  <= dec_d;
      done_q <= done_d;
    end
  end

  assign subkey    = pc2({c_q, d_q});
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: vector table plus scoreboard fed by a reference key-schedule model.
module tb_des_key_schedule;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h133457799BBCDFF0;
  localparam logic [51:0] E_K1  = {4'd0, 48'h1B02EFFC7072};
  localparam logic [51:0] E_K16 = {4'd15, 48'hCB3D8B0E17F5};

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          rmode;   // 0: always ready, 1: random ready, 2: stall 5 cycles at round 3
    logic        glitch;  // pulse start with another key mid-run
    logic        has_exp;
    logic [51:0] exp_first;
    logic [51:0] exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [63:0] key_i;
  logic        decrypt_i;
  logic        subkey_ready_i;
  logic        busy_o;
  logic [1:48] subkey_o;
  logic [3:0]  round_idx_o;
  logic        subkey_valid_o;
  logic        done_o;
  logic        parity_err_o;

  int          checks = 0;
  int          errors = 0;
  logic [51:0] sb_q [$];
  bit          capture_first;
  logic [51:0] first_acc;
  logic [51:0] last_acc;
  vec_t        vecs [7];

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_i),
    .key          (key_i),
    .decrypt      (decrypt_i),
    .busy         (busy_o),
    .subkey       (subkey_o),
    .round_idx    (round_idx_o),
    .subkey_valid (subkey_valid_o),
    .subkey_ready (subkey_ready_i),
    .done         (done_o),
    .parity_err   (parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference subkey K_n: rotate C0/D0 left by the cumulative shift count, then PC-2.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
    logic [1:64] kb;
    logic [1:28] c0, d0, c, d;
    logic [1:56] cd;
    logic [1:48] r;
    int t;
    kb = key;
    for (int i = 0; i < 28; i++) begin
      c0[i+1] = kb[PC1_T[i]];
      d0[i+1] = kb[PC1_T[i+28]];
    end
    t = 0;
    for (int i = 0; i < n; i++) t += SH_T[i];
    for (int i = 1; i <= 28; i++) begin
      c[i] = c0[((i - 1 + t) % 28) + 1];
      d[i] = d0[((i - 1 + t) % 28) + 1];
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[i+1] = cd[PC2_T[i]];
    return r;
  endfunction

  function automatic logic [63:0] all_outs();
    return {busy_o, subkey_valid_o, done_o, parity_err_o, round_idx_o, subkey_o};
  endfunction

  task automatic monitor();
    bit          stall_prev = 0;
    logic [51:0] stall_val  = '0;
    logic [51:0] got, exp;
    forever begin
      @(negedge clk);
      if (rst_n && subkey_valid_o) begin
        got = {round_idx_o, subkey_o};
        if (stall_prev) chk("stall_hold", got, stall_val);
        if (subkey_ready_i) begin
          if (sb_q.size() == 0) fail("sb_unexpected_subkey");
          else begin
            exp = sb_q.pop_front();
            chk("subkey_seq", got, exp);
          end
          if (capture_first) begin
            first_acc     = got;
            capture_first = 0;
          end
          last_acc   = got;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          stall_val  = got;
        end
      end else begin
        stall_prev = 0;
      end
    end
  endtask

  // Called at a negedge with the DUT idle (or in its done cycle); returns at the negedge where done is seen.
  task automatic run_schedule(input logic [63:0] k, input logic dec, input int rmode, input logic glitch);
    int cyc;
    int stalls;
    bit seen;
    for (int n = 1; n <= 16; n++) begin
      int kn;
      kn = dec ? 17 - n : n;
      sb_q.push_back({4'(kn - 1), model_k(k, kn)});
    end
    capture_first = 1;
    key_i     = k;
    decrypt_i = dec;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    key_i     = {$urandom, $urandom};
    decrypt_i = ~dec;
    cyc = 0; stalls = 0; seen = 0;
    subkey_ready_i = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 300 && !seen) begin
      @(negedge clk);
      if (done_o) seen = 1;
      else begin
        if (cyc == 0) begin
          chk("valid_latency", {subkey_valid_o, busy_o}, 2'b11);
          chk("perr_after_start", parity_err_o, 1'b0);
        end
        @(posedge clk);
        #1;
        if (glitch && cyc == 4) begin
          start_i   = 1'b1;
          key_i     = {$urandom, $urandom};
          decrypt_i = $urandom_range(0, 1);
        end else begin
          start_i = 1'b0;
        end
        case (rmode)
          0: subkey_ready_i = 1'b1;
          1: subkey_ready_i = 1'($urandom_range(0, 1));
          default: begin
            if (round_idx_o == 4'd3 && stalls < 5) begin
              subkey_ready_i = 1'b0;
              stalls++;
            end else subkey_ready_i = 1'b1;
          end
        endcase
        cyc++;
      end
    end
    if (!seen) fail("done_timeout");
    else begin
      chk("done_state", {busy_o, subkey_valid_o}, 2'b00);
      chk("sb_drained", sb_q.size(), 0);
      if (rmode == 0) chk("done_latency", cyc, 16);
      if (!dec) chk("cd_restored", subkey_o, model_k(k, 0));
    end
    subkey_ready_i = 1'b1;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{KEY_A, 1'b0, 0, 1'b0, 1'b1, E_K1, E_K16};
    vecs[1] = '{KEY_A, 1'b1, 0, 1'b0, 1'b1, {4'd15, E_K16[47:0]}, {4'd0, E_K1[47:0]}};
    vecs[2] = '{64'h0123456789ABCDEF, 1'b0, 1, 1'b0, 1'b0, '0, '0};
    vecs[3] = '{64'h0E329232EA6D0D73, 1'b1, 1, 1'b0, 1'b0, '0, '0};
    vecs[4] = '{KEY_A, 1'b0, 2, 1'b0, 1'b1, E_K1, E_K16};
    vecs[5] = '{64'hFEDCBA9876543210, 1'b0, 0, 1'b1, 1'b0, '0, '0};
    vecs[6] = '{64'h0101010101010101, 1'b1, 1, 1'b1, 1'b0, '0, '0};

    rst_n = 1'b0; start_i = 1'b0; key_i = '0; decrypt_i = 1'b0; subkey_ready_i = 1'b1;
    capture_first = 0; first_acc = '0; last_acc = '0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      key_i = {$urandom, $urandom};
      decrypt_i = $urandom_range(0, 1);
      @(negedge clk);
      chk("idle_outputs", all_outs(), 64'd0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      run_schedule(vecs[i].key, vecs[i].dec, vecs[i].rmode, vecs[i].glitch);
      if (vecs[i].has_exp) begin
        chk("first_subkey", first_acc, vecs[i].exp_first);
        chk("last_subkey", last_acc, vecs[i].exp_last);
      end
      @(negedge clk);
      chk("done_pulse_width", done_o, 1'b0);
    end

    // Back-to-back: second start issued in the done cycle
    @(negedge clk);
    run_schedule(KEY_A, 1'b0, 0, 1'b0);
    run_schedule(64'h0123456789ABCDEF, 1'b1, 0, 1'b0);
    chk("b2b_first", first_acc, {4'd15, model_k(64'h0123456789ABCDEF, 16)});
    @(negedge clk);
    chk("b2b_done_width", done_o, 1'b0);

    // Asynchronous reset in the middle of a run, then a clean restart
    @(negedge clk);
    for (int n = 1; n <= 16; n++) sb_q.push_back({4'(n - 1), model_k(KEY_A, n)});
    capture_first = 1;
    key_i = KEY_A; decrypt_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 0;
    while (cyc < 40 && round_idx_o != 4'd7) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (round_idx_o != 4'd7) fail("reach_round7_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", all_outs(), 64'd0);
    run_schedule(KEY_A, 1'b0, 0, 1'b0);
    chk("restart_first", first_acc, E_K1);

`ifdef DES_KEY_SCHEDULE_PARITY_CHK_EN
    @(negedge clk);
    @(negedge clk);
    key_i = KEY_B; decrypt_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("parity_reject", {parity_err_o, busy_o, subkey_valid_o}, 3'b100);
    end
    run_schedule(KEY_A, 1'b0, 0, 1'b0);
    chk("parity_cleared", parity_err_o, 1'b0);
    chk("parity_good_first", first_acc, E_K1);
`else
    @(negedge clk);
    @(negedge clk);
    run_schedule(KEY_B, 1'b0, 0, 1'b0);
    chk("parity_ignored_first", first_acc, E_K1);
    chk("parity_err_tied", parity_err_o, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low: clk (rising edge), rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new schedule; sampled only in IDLE.
REQ-005 key  input  [1:64]  DES key, bit 1 = MSB, bits 8/16/.../64 = parity bits.
REQ-006 decrypt  input  1  0 = emit K1..K16; 1 = emit K16..K1; sampled with start.
REQ-007 busy  output  1  high from accepted start until the last subkey is accepted.
REQ-008 subkey  output  [1:48]  current round subkey, bit 1 = MSB; this is the 48-bit value XORed with the expanded R half ahead of the S-box stage.
REQ-009 round_idx  output  [3:0]  current DES key index minus 1 (0..15); in decrypt this counts down from 15.
REQ-010 subkey_valid  output  1  subkey/round_idx are valid.
REQ-011 subkey_ready  input  1  downstream accepts the subkey when high with subkey_valid.
REQ-012 done  output  1  one-cycle pulse after the 16th subkey is accepted.
REQ-013 parity_err  output  1  key parity failure flag (see Configuration).

Function
REQ-014 Two states: IDLE and RUN.
REQ-015 IDLE + start=1: latch PC-1(key) into 28-bit C and D registers; latch decrypt; enter RUN; busy=1.
REQ-016 Encrypt load: C/D SHALL be stored already rotated left by 1 (round-1 shift); decrypt load: C/D SHALL be stored unrotated (C16=C0).
REQ-017 subkey SHALL equal PC-2(C||D) of the current registers.
REQ-018 subkey_valid SHALL rise the cycle after start is accepted, giving 1-cycle latency.
REQ-019 Advance only on subkey_valid && subkey_ready; while subkey_ready=0, subkey, round_idx and C/D SHALL hold.
REQ-020 Encrypt advance: rotate C and D left by s[n+1], with s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 Decrypt advance: rotate C and D right by s[16-step], giving right shifts 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022 Acceptance of the 16th subkey SHALL cause the following to occur on the next cycle: subkey_valid=0, busy=0, done=1 for one cycle, and a return to IDLE.
REQ-023 start SHALL be ignored in RUN, and key/decrypt changes in RUN SHALL have no effect.
REQ-024 Back-to-back: start in the cycle done=1 (IDLE) SHALL be accepted.
REQ-025 C/D SHALL remain unchanged after 16 steps, so a completed encrypt schedule leaves C/D equal to the initial PC-1 value.

Reset
REQ-026 rst_n=0 SHALL force the following at any time, including mid-RUN: IDLE; C, D, subkey, and round_idx = 0; subkey_valid, busy, done, and parity_err = 0.
REQ-027 After reset release, no output SHALL change until the first accepted start.

Configuration
REQ-028 The macro DES_KEY_SCHEDULE_PARITY_CHK_EN SHALL enable odd-parity checking of each key byte at start.
REQ-029 With DES_KEY_SCHEDULE_PARITY_CHK_EN defined, a start whose key has any even-parity byte SHALL be rejected: the block stays in IDLE, busy stays 0, and parity_err=1 from the next cycle until the next good start is accepted or reset.
REQ-030 Without DES_KEY_SCHEDULE_PARITY_CHK_EN, parity_err SHALL be tied to 0, parity bits SHALL be ignored, and every IDLE start SHALL be accepted.

Verification
REQ-031 Encrypt with key=133457799BBCDFF1 and subkey_ready=1 SHALL produce the following: first subkey=1B02EFFC7072 with round_idx=0, and 16th subkey=CB3D8B0E17F5; done pulses one cycle later.
REQ-032 Decrypt with the same key SHALL produce the following: first subkey=CB3D8B0E17F5 with round_idx=15, and last subkey=1B02EFFC7072 with round_idx=0.
REQ-033 In an encrypt run, holding subkey_ready=0 for 5 cycles at round_idx=3 SHALL keep subkey/round_idx stable, and the sequence SHALL then resume unchanged with no skipped or duplicated round.
REQ-034 Asserting rst_n=0 at round_idx=7 SHALL zero all outputs asynchronously, and a new start after release SHALL restart the sequence at K1.
REQ-035 Pulsing start with a different key mid-RUN SHALL be ignored, and a start in the done cycle SHALL be accepted with valid one cycle later.
REQ-036 With DES_KEY_SCHEDULE_PARITY_CHK_EN defined, key=133457799BBCDFF0 SHALL give parity_err=1 with no subkey_valid, and key=133457799BBCDFF1 SHALL then clear parity_err and run.
